// File: rtl/demux_1x2_blanked.sv
// Registered 1-to-2 sample demultiplexer with break-before-make blanking on route changes.
// Both outputs read 0 for BLANK_CYCLES cycles whenever the selected route moves.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_ROUTE | active route live: out[active] follows in_i, other output 0
// ST_BLANK | route change in progress: both outputs 0, counter runs to 0
module demux_1x2_blanked #(
    parameter int WIDTH        = 16,
    parameter int BLANK_CYCLES = 125
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sel_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out0_o,
    output logic [WIDTH-1:0] out1_o,
    output logic             busy_o
);

    localparam int               CNT_W      = $clog2(BLANK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_ROUTE = 1'b0,
        ST_BLANK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             active_q, active_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic             busy_q, busy_d;

    logic             route_live;
    logic             route_sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_ROUTE;
            active_q  <= 1'b0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            out0_q    <= '0;
            out1_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            ST_ROUTE: begin
                if (sel_i != active_q) begin
                    pending_d = sel_i;
                    cnt_d     = CNT_RELOAD;
                    state_d   = ST_BLANK;
                end
            end
            ST_BLANK: begin
                // A request change mid-blank always restarts the full blank, even back to active.
                if (sel_i != pending_q) begin
                    pending_d = sel_i;
                    cnt_d     = CNT_RELOAD;
                end else if (cnt_q == '0) begin
                    active_d = pending_q;
                    state_d  = ST_ROUTE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_ROUTE;
        endcase
    end

    // The new route goes live on the same edge that the blank terminates.
    always_comb begin
        route_live = 1'b0;
        route_sel  = active_q;
        if (state_q == ST_ROUTE) begin
            route_live = (sel_i == active_q);
            route_sel  = active_q;
        end else begin
            route_live = (sel_i == pending_q) && (cnt_q == '0);
            route_sel  = pending_q;
        end
        out0_d = (route_live && !route_sel) ? in_i : '0;
        out1_d = (route_live &&  route_sel) ? in_i : '0;
        busy_d = !route_live;
    end

    assign out0_o = out0_q;
    assign out1_o = out1_q;
    assign busy_o = busy_q;

endmodule
